melody_sequencer: RTL and testbench

- Upstream score player for the square-wave tone generator.
- Walks a score ROM of note entries, each a note code plus a duration in beats, and inserts a short silent gap between notes.
- Presents a registered 18-bit half-period-table value (note_period) and a sound-enable flag (note_valid) to the tone generator.
- Controlled by debounced one-cycle play/pause and stop key pulses.

---
 rtl/melody_pkg.sv | 48 ++++
 rtl/melody_rom.sv | 25 ++
 rtl/melody_sequencer.sv | 162 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: note codes, period table,
// FSM encoding and ROM entry field positions.
package melody_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SO   = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  localparam logic [17:0] PER_DO = 18'd190839;
  localparam logic [17:0] PER_RE = 18'd170067;
  localparam logic [17:0] PER_MI = 18'd151514;
  localparam logic [17:0] PER_FA = 18'd143265;
  localparam logic [17:0] PER_SO = 18'd127550;
  localparam logic [17:0] PER_LA = 18'd113635;
  localparam logic [17:0] PER_SI = 18'd101213;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_PAUSE} state_e;

  localparam int CODE_HI = 7;
  localparam int CODE_LO = 4;
  localparam int DUR_HI  = 3;
  localparam int DUR_LO  = 0;

  // Codes 1..7 sound; 0 and 8..15 are rests.
  function automatic logic is_tone(input logic [3:0] code);
    return (code != NOTE_REST) && !code[3];
  endfunction

  // Rests keep the previous period so the tone generator sees no glitch.
  function automatic logic [17:0] period_of(input logic [3:0] code, input logic [17:0] prev);
    case (code)
      NOTE_DO: period_of = PER_DO;
      NOTE_RE: period_of = PER_RE;
      NOTE_MI: period_of = PER_MI;
      NOTE_FA: period_of = PER_FA;
      NOTE_SO: period_of = PER_SO;
      NOTE_LA: period_of = PER_LA;
      NOTE_SI: period_of = PER_SI;
      default: period_of = prev;
    endcase
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational 64x8 score ROM: {note code, duration in beats}.
module melody_rom
  import melody_pkg::*;
(
  input  logic [5:0] addr,
  output logic [7:0] entry
);

  // Default score: DO..SI two beats each, one rest beat, then end markers.
  always_comb begin
    entry = {NOTE_REST, 4'd0};
    case (addr)
      6'd0: entry = {NOTE_DO,   4'd2};
      6'd1: entry = {NOTE_RE,   4'd2};
      6'd2: entry = {NOTE_MI,   4'd2};
      6'd3: entry = {NOTE_FA,   4'd2};
      6'd4: entry = {NOTE_SO,   4'd2};
      6'd5: entry = {NOTE_LA,   4'd2};
      6'd6: entry = {NOTE_SI,   4'd2};
      6'd7: entry = {NOTE_REST, 4'd1};
      default: entry = {NOTE_REST, 4'd0};
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Score player: walks the ROM, times notes in beats, inserts silent gaps,
// and supports pause/resume and stop.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter logic [24:0] TICK_MAX = 25'd12499999,
  parameter logic [19:0] GAP_MAX  = 20'd999999,
  parameter logic [6:0]  SONG_LEN = 7'd64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_play,
  input  logic        key_stop,
  input  logic        loop_en,
  output logic [17:0] note_period,
  output logic        note_valid,
  output logic [5:0]  note_idx,
  output logic        playing,
  output logic        song_done
);

  state_e      state, nstate, resume_st, d_resume;
  logic [24:0] tick_cnt, d_tick;
  logic [3:0]  beat_cnt, d_beat;
  logic [19:0] gap_cnt, d_gap;
  logic [5:0]  addr, d_addr, addr_inc, rom_addr;
  logic [17:0] d_period;
  logic        d_valid, d_done;
  logic [7:0]  cur_entry, first_entry;
  logic [3:0]  cur_code, cur_dur, first_code, first_dur;
  logic        play_end, gap_end;

  assign addr_inc = ({1'b0, addr} == SONG_LEN - 7'd1) ? 6'd0 : addr + 6'd1;
  assign gap_end  = (gap_cnt == GAP_MAX);
  // On the last gap cycle look ahead at the next entry so it loads on the same edge.
  assign rom_addr = (state == ST_GAP && gap_end) ? addr_inc : addr;

  melody_rom u_rom_cur   (.addr(rom_addr), .entry(cur_entry));
  melody_rom u_rom_first (.addr(6'd0),     .entry(first_entry));

  assign cur_code   = cur_entry[CODE_HI:CODE_LO];
  assign cur_dur    = cur_entry[DUR_HI:DUR_LO];
  assign first_code = first_entry[CODE_HI:CODE_LO];
  assign first_dur  = first_entry[DUR_HI:DUR_LO];
  assign play_end   = (tick_cnt == TICK_MAX) && (beat_cnt == cur_dur - 4'd1);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= nstate;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (key_play && first_dur != 4'd0) nstate = ST_PLAY;
      ST_PLAY:  if (key_play) nstate = ST_PAUSE;
                else if (play_end) nstate = ST_GAP;
      ST_GAP:   if (key_play) nstate = ST_PAUSE;
                else if (gap_end) begin
                  if (cur_dur != 4'd0)                   nstate = ST_PLAY;
                  else if (loop_en && first_dur != 4'd0) nstate = ST_PLAY;
                  else                                   nstate = ST_IDLE;
                end
      ST_PAUSE: if (key_play) nstate = resume_st;
      default:  nstate = ST_IDLE;
    endcase
    if (key_stop) nstate = ST_IDLE;
  end

  // Next values for counters and registered outputs. A pause edge still
  // consumes the current cycle, except the final gap cycle which is replayed.
  always_comb begin
    d_tick   = tick_cnt;
    d_beat   = beat_cnt;
    d_gap    = gap_cnt;
    d_addr   = addr;
    d_period = note_period;
    d_valid  = note_valid;
    d_done   = 1'b0;
    d_resume = resume_st;
    case (state)
      ST_IDLE: if (key_play) begin
        if (first_dur != 4'd0) begin
          d_addr = 6'd0; d_tick = '0; d_beat = '0; d_gap = '0;
          d_period = period_of(first_code, note_period);
          d_valid  = is_tone(first_code);
        end else begin
          d_done = 1'b1;
        end
      end
      ST_PLAY: begin
        if (play_end) begin
          d_tick = '0; d_beat = '0; d_gap = '0; d_valid = 1'b0;
        end else if (tick_cnt == TICK_MAX) begin
          d_tick = '0; d_beat = beat_cnt + 4'd1;
        end else begin
          d_tick = tick_cnt + 25'd1;
        end
        if (key_play) begin
          d_valid  = 1'b0;
          d_resume = play_end ? ST_GAP : ST_PLAY;
        end
      end
      ST_GAP: begin
        if (key_play) d_resume = ST_GAP;
        if (!gap_end) begin
          d_gap = gap_cnt + 20'd1;
        end else if (!key_play) begin
          d_gap = '0; d_tick = '0; d_beat = '0;
          if (cur_dur != 4'd0) begin
            d_addr   = addr_inc;
            d_period = period_of(cur_code, note_period);
            d_valid  = is_tone(cur_code);
          end else begin
            d_done = 1'b1;
            d_addr = 6'd0;
            if (loop_en && first_dur != 4'd0) begin
              d_period = period_of(first_code, note_period);
              d_valid  = is_tone(first_code);
            end
          end
        end
      end
      ST_PAUSE: if (key_play) d_valid = (resume_st == ST_PLAY) && is_tone(cur_code);
      default: ;
    endcase
    if (key_stop) begin
      d_tick = '0; d_beat = '0; d_gap = '0; d_addr = 6'd0;
      d_valid = 1'b0; d_done = 1'b0; d_resume = ST_PLAY;
    end
  end

  // Datapath and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt    <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      addr        <= '0;
      resume_st   <= ST_PLAY;
      note_period <= PER_DO;
      note_valid  <= 1'b0;
      song_done   <= 1'b0;
      playing     <= 1'b0;
    end else begin
      tick_cnt    <= d_tick;
      beat_cnt    <= d_beat;
      gap_cnt     <= d_gap;
      addr        <= d_addr;
      resume_st   <= d_resume;
      note_period <= d_period;
      note_valid  <= d_valid;
      song_done   <= d_done;
      playing     <= (nstate != ST_IDLE);
    end
  end

  assign note_idx = addr;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with short beat/gap timing.
module tb_melody_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        key_play = 1'b0;
  logic        key_stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [17:0] note_period;
  logic        note_valid;
  logic [5:0]  note_idx;
  logic        playing;
  logic        song_done;

  int errors = 0;
  int checks = 0;
  int ones, first_low, done_cyc, done_cnt, seen7, bad7, bad, drop;

  always #5 sys_clk = ~sys_clk;

  melody_sequencer #(
    .TICK_MAX(25'd9), .GAP_MAX(20'd3), .SONG_LEN(7'd64)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_play(key_play),
    .key_stop(key_stop), .loop_en(loop_en), .note_period(note_period),
    .note_valid(note_valid), .note_idx(note_idx), .playing(playing),
    .song_done(song_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // 1: reset state held while idle
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    check("rst valid",  note_valid, 0);
    check("rst period", note_period, 190839);
    check("rst idx",    note_idx, 0);
    check("rst playing", playing, 0);
    check("rst done",   song_done, 0);

    // 2+3: play the whole song, no loop
    key_play = 1'b1;
    ones = 0; first_low = 0; done_cyc = 0; done_cnt = 0; seen7 = 0; bad7 = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge sys_clk);
      key_play = 1'b0;
      if (c <= 24) begin
        if (note_valid) ones++;
        else if (first_low == 0) first_low = c;
      end
      if (c == 1) check("t2 playing", playing, 1);
      if (c == 25) begin
        check("t2 period RE", note_period, 170067);
        check("t2 idx 1",     note_idx, 1);
        check("t2 valid RE",  note_valid, 1);
      end
      if (note_idx == 6'd7) begin
        seen7++;
        if (note_valid || note_period != 18'd101213) bad7++;
      end
      if (song_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (done_cyc != 0 && c == done_cyc + 1) begin
        check("t3 done width", song_done, 0);
        check("t3 idle playing", playing, 0);
        check("t3 idle idx", note_idx, 0);
      end
    end
    check("t2 DO valid cycles", ones, 20);
    check("t2 first gap cycle", first_low, 21);
    check("t3 rest cycles", seen7, 14);
    check("t3 rest bad", bad7, 0);
    check("t3 done cycle", done_cyc, 183);
    check("t3 done count", done_cnt, 1);

    // 4: pause at cycle 5 of DO, hold 30 cycles, resume
    key_play = 1'b1;
    ones = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge sys_clk);
      key_play = (c == 5);
      if (note_valid) ones++;
    end
    check("t4 pre-pause", ones, 5);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge sys_clk);
      key_play = 1'b0;
      if (note_valid || !playing || note_idx != 6'd0 || note_period != 18'd190839) bad++;
    end
    check("t4 paused bad", bad, 0);
    key_play = 1'b1;
    ones = 0; first_low = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sys_clk);
      key_play = 1'b0;
      if (first_low == 0) begin
        if (note_valid) ones++;
        else first_low = c;
      end
    end
    check("t4 resumed cycles", ones, 15);
    check("t4 gap after resume", first_low, 16);

    // 5: stop and play together at note 3
    for (int c = 0; c < 300 && note_idx != 6'd3; c++) @(negedge sys_clk);
    check("t5 reached idx3", note_idx, 3);
    key_stop = 1'b1; key_play = 1'b1;
    @(negedge sys_clk);
    key_stop = 1'b0; key_play = 1'b0;
    check("t5 idx", note_idx, 0);
    check("t5 valid", note_valid, 0);
    check("t5 playing", playing, 0);
    done_cnt = song_done ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      if (song_done) done_cnt++;
    end
    check("t5 no done", done_cnt, 0);
    check("t5 still idle", playing, 0);

    // 6: looping song
    loop_en = 1'b1;
    key_play = 1'b1;
    done_cyc = 0; drop = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge sys_clk);
      key_play = 1'b0;
      if (!playing) drop++;
      if (song_done && done_cyc == 0) begin
        done_cyc = c;
        check("t6 loop idx", note_idx, 0);
        check("t6 loop period", note_period, 190839);
        check("t6 loop valid", note_valid, 1);
      end
    end
    check("t6 done cycle", done_cyc, 183);
    check("t6 playing drops", drop, 0);

    // asynchronous reset mid-note
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst valid", note_valid, 0);
    check("arst playing", playing, 0);
    check("arst idx", note_idx, 0);
    check("arst period", note_period, 190839);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
